ps2_key_decoder: RTL and testbench

PS/2 keyboard front end. It receives 11-bit device-to-host frames from the keyboard and checks start, parity and stop bits. It folds the E0 (extended) and F0 (break) prefix bytes into flags and emits one key_event per completed scan code. key_event feeds the game top-level key-press logic, which treats [10] as the event strobe, [9] as the extended flag, [8] as the break flag and [7:0] as the scan code.

---
 rtl/ps2_key_decoder.sv | 165 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronise, deglitch, deframe and fold E0/F0 prefixes into key events.
// Optional macro PS2_PARITY_CHK_EN enables odd-parity checking (default: parity ignored).
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] key_event,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

`ifdef PS2_PARITY_CHK_EN
    localparam bit ParChk = 1'b1;
`else
    localparam bit ParChk = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt, r_filt_d;
    logic [FW-1:0] r_fcnt;
    logic          w_fall;

    state_e        r_state, w_state_d;
    logic [2:0]    r_bit_cnt, w_bit_cnt_d;
    logic [7:0]    r_sh, w_sh_d;
    logic          r_par, w_par_d;
    logic          r_ext_f, w_ext_d;
    logic          r_brk_f, w_brk_d;
    logic [10:0]   r_key_event, w_key_d;
    logic          r_err, w_err_d;
    logic [TW-1:0] r_to_cnt, w_to_cnt_d;
    logic          w_par_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_filt_d <= r_filt;
            // Filtered clock only follows a level that has persisted FILTER_LEN cycles
            if (r_clk_s2 != r_filt) begin
                if (r_fcnt == FW'(FILTER_LEN - 1)) begin
                    r_filt <= r_clk_s2;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + FW'(1);
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    assign w_fall   = r_filt_d & ~r_filt;
    assign w_par_ok = !ParChk || (^{r_sh, r_par});

    always_comb begin
        w_state_d   = r_state;
        w_bit_cnt_d = r_bit_cnt;
        w_sh_d      = r_sh;
        w_par_d     = r_par;
        w_ext_d     = r_ext_f;
        w_brk_d     = r_brk_f;
        w_key_d     = {1'b0, r_key_event[9:0]};
        w_err_d     = 1'b0;
        if (r_state == StIdle || w_fall) begin
            w_to_cnt_d = '0;
        end else begin
            w_to_cnt_d = r_to_cnt + TW'(1);
        end

        if (r_state != StIdle && r_to_cnt == TW'(TIMEOUT_CYC)) begin
            w_state_d  = StIdle;
            w_ext_d    = 1'b0;
            w_brk_d    = 1'b0;
            w_err_d    = 1'b1;
            w_to_cnt_d = '0;
        end else if (w_fall) begin
            unique case (r_state)
                StIdle: begin
                    if (!r_dat_s2) begin
                        w_state_d   = StData;
                        w_bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    w_sh_d      = {r_dat_s2, r_sh[7:1]};
                    w_bit_cnt_d = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_d = StParity;
                    end
                end
                StParity: begin
                    w_par_d   = r_dat_s2;
                    w_state_d = StStop;
                end
                StStop: begin
                    w_state_d = StIdle;
                    if (r_dat_s2 && w_par_ok) begin
                        if (r_sh == 8'hE0) begin
                            w_ext_d = 1'b1;
                        end else if (r_sh == 8'hF0) begin
                            w_brk_d = 1'b1;
                        end else begin
                            w_key_d = {1'b1, r_ext_f, r_brk_f, r_sh};
                            w_ext_d = 1'b0;
                            w_brk_d = 1'b0;
                        end
                    end else begin
                        w_err_d = 1'b1;
                        w_ext_d = 1'b0;
                        w_brk_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= StIdle;
            r_bit_cnt   <= '0;
            r_sh        <= '0;
            r_par       <= 1'b0;
            r_ext_f     <= 1'b0;
            r_brk_f     <= 1'b0;
            r_key_event <= '0;
            r_err       <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_state     <= w_state_d;
            r_bit_cnt   <= w_bit_cnt_d;
            r_sh        <= w_sh_d;
            r_par       <= w_par_d;
            r_ext_f     <= w_ext_d;
            r_brk_f     <= w_brk_d;
            r_key_event <= w_key_d;
            r_err       <= w_err_d;
            r_to_cnt    <= w_to_cnt_d;
        end
    end

    assign key_event = r_key_event;
    assign frame_err = r_err;
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: expected key events queued as frames are sent,
// popped when the DUT strobes.
module tb_ps2_key_decoder;

    localparam int unsigned FILTER_LEN  = 8;
    localparam int unsigned TIMEOUT_CYC = 3000;
    localparam int          HALF        = 40;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] key_event;
    logic        frame_err;
    logic        busy;

    int          n_total = 0;
    int          n_bad = 0;
    int          n_evt = 0;
    int          n_err = 0;
    int          n_push = 0;
    int          exp_err = 0;
    logic [10:0] exp_q[$];
    logic        prev_stb = 1'b0;
    logic        prev_err = 1'b0;

    ps2_key_decoder #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_dut (
        .clk      (clk),
        .rstn     (rstn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_event(key_event),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clks(HALF);
        ps2_clk = 1'b0;
        wait_clks(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(stop);
        ps2_data = 1'b1;
        wait_clks(2 * HALF);
        check_eq("busy_after_frame", {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_evt(input logic [10:0] e);
        exp_q.push_back(e);
        n_push++;
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (key_event[10]) begin
                n_evt++;
                check_eq("strobe_1cyc", {31'd0, prev_stb}, 32'd0);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_evt", {21'd0, key_event}, 32'd0);
                end else begin
                    check_eq("key_event", {21'd0, key_event}, {21'd0, exp_q.pop_front()});
                end
            end
            if (frame_err) begin
                n_err++;
                check_eq("err_1cyc", {31'd0, prev_err}, 32'd0);
            end
        end
        prev_stb = key_event[10];
        prev_err = frame_err;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        #23;
        check_eq("rst_key_event", {21'd0, key_event}, 32'd0);
        check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        wait_clks(20);

        // Make code
        expect_evt(11'h41D);
        send_frame(8'h1D, 1'b0, 1'b1);
        check_eq("make_evt_cnt", n_evt, 1);
        check_eq("make_err_cnt", n_err, 0);
        check_eq("make_hold", {21'd0, key_event}, 32'h01D);

        // Break, then flags cleared
        send_frame(8'hF0, 1'b0, 1'b1);
        check_eq("no_evt_after_f0", n_evt, 1);
        expect_evt(11'h51D);
        send_frame(8'h1D, 1'b0, 1'b1);
        expect_evt(11'h41D);
        send_frame(8'h1D, 1'b0, 1'b1);

        // Extended keys
        send_frame(8'hE0, 1'b0, 1'b1);
        expect_evt(11'h675);
        send_frame(8'h75, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        expect_evt(11'h775);
        send_frame(8'h75, 1'b0, 1'b1);
        check_eq("ext_evt_cnt", n_evt, 5);

        // Bad parity with an E0 pending
        send_frame(8'hE0, 1'b0, 1'b1);
`ifdef PS2_PARITY_CHK_EN
        exp_err++;
`else
        expect_evt(11'h61C);
`endif
        send_frame(8'h1C, 1'b1, 1'b1);
        check_eq("par_err_cnt", n_err, exp_err);
        expect_evt(11'h46B);
        send_frame(8'h6B, 1'b0, 1'b1);

        // Bad stop bit with an F0 pending clears the break flag
        send_frame(8'hF0, 1'b0, 1'b1);
        exp_err++;
        send_frame(8'h2A, 1'b0, 1'b0);
        check_eq("stop_err_cnt", n_err, exp_err);
        expect_evt(11'h42A);
        send_frame(8'h2A, 1'b0, 1'b1);

        // Timeout mid-frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        check_eq("busy_mid_frame", {31'd0, busy}, 32'd1);
        e0 = n_err;
        for (int i = 0; i < 2 * TIMEOUT_CYC && n_err == e0; i++) wait_clks(1);
        exp_err++;
        check_eq("timeout_err_cnt", n_err, exp_err);
        wait_clks(2);
        check_eq("timeout_busy", {31'd0, busy}, 32'd0);
        expect_evt(11'h423);
        send_frame(8'h23, 1'b0, 1'b1);

        // Short clock glitches with data low must not start a frame
        ps2_data = 1'b0;
        for (int g = 0; g < 4; g++) begin
            ps2_clk = 1'b0;
            wait_clks(FILTER_LEN - 2);
            ps2_clk = 1'b1;
            for (int k = 0; k < 20; k++) begin
                wait_clks(1);
                if (busy) check_eq("glitch_busy", {31'd0, busy}, 32'd0);
            end
        end
        check_eq("glitch_busy_end", {31'd0, busy}, 32'd0);
        ps2_data = 1'b1;
        wait_clks(10);
        expect_evt(11'h45A);
        send_frame(8'h5A, 1'b0, 1'b1);

        // Reset mid-frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check_eq("busy_before_rst", {31'd0, busy}, 32'd1);
        ps2_clk = 1'b0;
        wait_clks(20);
        #3 rstn = 1'b0;
        #1;
        check_eq("midrst_key_event", {21'd0, key_event}, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clks(10);
        rstn = 1'b1;
        wait_clks(50);
        check_eq("post_rst_err_cnt", n_err, exp_err);
        check_eq("post_rst_key_event", {21'd0, key_event}, 32'd0);
        expect_evt(11'h41D);
        send_frame(8'h1D, 1'b0, 1'b1);

        check_eq("sb_empty", exp_q.size(), 0);
        check_eq("evt_total", n_evt, n_push);
        check_eq("err_total", n_err, exp_err);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
